window_filter_pipe: RTL and testbench
=====================================

Name: window_filter_pipe

Overview:
- Parametrised, pipelined successor of the single-mode 3x3 window operator: accepts one MASK_WIDTH x MASK_WIDTH pixel window per beat and produces one filtered pixel.
- Run-time mode select: Laplacian edge, box (shifted sum), min (erode), max (dilate).
- Valid/ready backpressure on both sides; output saturates instead of truncating.
- Sits between the line-buffer/window-former and the output pixel sink of the spatial filter chain.

Parameters:
- PIX_BIT, 8, bits per pixel.
- MASK_WIDTH, 3, window side; odd, 3..7. K = MASK_WIDTH**2.
- BOX_SHIFT, 3, right shift applied to the window sum in box mode.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- win_in  in  PIX_BIT*K  window pixels.
- win_valid  in  1  win_in/mode_in valid.
- win_ready  out  1  block accepts a beat this cycle.
- mode_in  in  2  0 = laplacian, 1 = box, 2 = min, 3 = max; sampled with the beat.
- pix_out  out  PIX_BIT  result pixel.
- pix_valid  out  1  pix_out valid.
- pix_ready  in  1  sink accepts pix_out.

Behaviour:
- Reset (reset low, async): all stage valids = 0, pix_out = 0, pix_valid = 0, win_ready = 1 once reset is released. Asserting reset mid-operation discards all in-flight beats; no output follows.
- Pixel i (0..K-1, raster order) = win_in[PIX_BIT*(i+1)-1 : PIX_BIT*i]. Centre index C = (K-1)/2.
- Handshake: a beat transfers on win_valid & win_ready; a result transfers on pix_valid & pix_ready.
  - pix_out and pix_valid are held stable while pix_valid & !pix_ready.
  - win_valid may drop without a handshake. win_in is not required to be held.
- Pipeline: 3 register stages, latency exactly 3 cycles from the accept edge to pix_valid with no stall.
  - S1: register the window and mode.
  - S2: adder tree sumN (all pixels except C), min/max trees over all K pixels, cen = pixel C.
  - S3: mode select, absolute value, saturation; drives pix_out.
- Stall rule: stage s advances iff its successor is empty or advancing. win_ready = !S1_valid | S1_advance.
  - Full throughput of 1 beat/cycle with pix_ready held high.
  - A 3-deep stall holds 3 beats with no loss or duplication.
  - On release, beats drain in order, one per cycle.
- Mode travels with its beat; changing mode_in between beats never affects beats already accepted.
- Arithmetic, with SW = PIX_BIT + clog2(K) + 1 bits (unsigned sums, signed difference):
  - laplacian: |sumN - (K-1)*cen|, saturated to 2**PIX_BIT - 1.
  - box: (sumN + cen) >> BOX_SHIFT, saturated.
  - min / max: exact, no saturation needed.
- Simultaneous accept and emit in the same cycle is legal and required for full throughput.

Optional Feature:
- Macro: WINDOW_FILTER_THRESH_EN.
- Defined:
  - Adds ports thresh_in (in, PIX_BIT) and thresh_on (in, 1), both sampled with the beat.
  - When the beat's thresh_on = 1, S3 output becomes (result >= thresh) ? all-ones : 0.
  - No extra latency.
- Undefined: ports absent; output is the raw mode result.

Decomposition:
- Package window_filter_pkg holds:
  - mode encodings: MODE_LAP = 2'd0, MODE_BOX = 2'd1, MODE_MIN = 2'd2, MODE_MAX = 2'd3;
  - the clog2 width helper;
  - the saturate function.
- Sub-module window_reduce_tree: parametrised combinational tree producing sumN, min and max over K pixels. Used in S2 and instantiated once. The top keeps the pipeline and handshake.

Test Plan (defaults: PIX_BIT = 8, MASK_WIDTH = 3):
- Laplacian, all pixels 10 -> pix_out = 0 exactly 3 cycles after accept. Centre 50, others 10 -> |80 - 400| = 320 -> saturated 255.
- Box, all pixels 8 -> 72 >> 3 = 9. All 255 -> 2295 >> 3 = 286 -> saturated 255.
- Min/max, window 1..9 (centre 5) -> min = 1, max = 9. Back-to-back beats alternate mode 2/3 -> outputs 1, 9, 1, 9 in order.
- Backpressure: stream 6 beats (values 1..6, box mode, all pixels equal) with pix_ready low for cycles 4..9.
  - win_ready drops after 3 beats are held.
  - pix_out held stable during the stall.
  - Outputs 1..6 with no loss or duplication after release.
- Reset asserted (low) with 3 beats in flight -> pix_valid = 0 immediately. After release, no stale output appears and the next beat has latency 3.
- WINDOW_FILTER_THRESH_EN defined, thresh = 100, thresh_on = 1, max mode, window max 120 -> 255. Window max 99 -> 0.

Source files
------------

// File: rtl/window_filter_pkg.sv
// window_filter_pkg: mode encodings, width helper and saturation shared by window_filter_pipe
package window_filter_pkg;
   localparam logic [1:0] MODE_LAP = 2'd0;
   localparam logic [1:0] MODE_BOX = 2'd1;
   localparam logic [1:0] MODE_MIN = 2'd2;
   localparam logic [1:0] MODE_MAX = 2'd3;
   function automatic int clog2w(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w = w + 1;
      return w;
   endfunction
   function automatic logic [31:0] saturate(input logic [31:0] v, input int pix_bit);
      logic [31:0] lim;
      lim = (32'd1 << pix_bit) - 32'd1;
      return (v > lim) ? lim : v;
   endfunction
endpackage

// File: rtl/window_filter_pipe_tree.sv
// window_reduce_tree: balanced combinational tree giving sum (centre excluded), min and max of a window
module window_reduce_tree #(
   parameter int PIX_BIT = 8,
   parameter int K = 9,
   parameter int SW = 13
) (
   input  logic [PIX_BIT*K-1:0] win,
   output logic [SW-1:0] sum_n,
   output logic [PIX_BIT-1:0] min_pix,
   output logic [PIX_BIT-1:0] max_pix
);
   import window_filter_pkg::*;
   localparam int C = (K - 1) / 2;
   localparam int P = 1 << clog2w(K);
   // heap layout: node n has children 2n and 2n+1, leaves start at P; padding leaves are neutral
   always_comb begin
      logic [SW-1:0] s [1:2*P-1];
      logic [PIX_BIT-1:0] lo [1:2*P-1];
      logic [PIX_BIT-1:0] hi [1:2*P-1];
      for (int n = 1; n < 2 * P; n++) begin
         s[n] = '0;
         lo[n] = '1;
         hi[n] = '0;
      end
      for (int n = 0; n < K; n++) begin
         s[P+n] = (n == C) ? '0 : SW'(win[PIX_BIT*n +: PIX_BIT]);
         lo[P+n] = win[PIX_BIT*n +: PIX_BIT];
         hi[P+n] = win[PIX_BIT*n +: PIX_BIT];
      end
      for (int n = P - 1; n >= 1; n--) begin
         s[n] = s[2*n] + s[2*n+1];
         lo[n] = (lo[2*n] < lo[2*n+1]) ? lo[2*n] : lo[2*n+1];
         hi[n] = (hi[2*n] > hi[2*n+1]) ? hi[2*n] : hi[2*n+1];
      end
      sum_n = s[1];
      min_pix = lo[1];
      max_pix = hi[1];
   end
endmodule

// File: rtl/window_filter_pipe.sv
// window_filter_pipe: 3-stage laplacian/box/min/max window filter with valid/ready on both sides.
// Defining WINDOW_FILTER_THRESH_EN adds per-beat thresh_in/thresh_on binarisation of the result.
module window_filter_pipe #(
   parameter int PIX_BIT = 8,
   parameter int MASK_WIDTH = 3,
   parameter int BOX_SHIFT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic [PIX_BIT*MASK_WIDTH*MASK_WIDTH-1:0] win_in,
   input  logic win_valid,
   output logic win_ready,
   input  logic [1:0] mode_in,
`ifdef WINDOW_FILTER_THRESH_EN
   input  logic [PIX_BIT-1:0] thresh_in,
   input  logic thresh_on,
`else
`endif
   output logic [PIX_BIT-1:0] pix_out,
   output logic pix_valid,
   input  logic pix_ready
);
   import window_filter_pkg::*;
   localparam int K = MASK_WIDTH * MASK_WIDTH;
   localparam int C = (K - 1) / 2;
   localparam int SW = PIX_BIT + clog2w(K) + 1;
   logic s1_v, s2_v;
   logic [PIX_BIT*K-1:0] s1_win;
   logic [1:0] s1_mode, s2_mode;
   logic [SW-1:0] s2_sum, t_sum;
   logic [PIX_BIT-1:0] s2_min, s2_max, s2_cen, t_min, t_max;
   logic s3_ld, s2_adv, s2_ld, s1_adv;
   logic [SW-1:0] cen_w, lap_prod, lap_abs, box_val;
   logic [PIX_BIT-1:0] raw, res;
`ifdef WINDOW_FILTER_THRESH_EN
   logic [PIX_BIT-1:0] s1_thr, s2_thr;
   logic s1_thr_on, s2_thr_on;
`else
`endif
   // a stage moves forward only when the stage after it is empty or moving too
   assign s3_ld = !pix_valid | pix_ready;
   assign s2_adv = s2_v & s3_ld;
   assign s2_ld = !s2_v | s2_adv;
   assign s1_adv = s1_v & s2_ld;
   assign win_ready = !s1_v | s1_adv;
   window_reduce_tree #(.PIX_BIT(PIX_BIT), .K(K), .SW(SW)) u_tree (
      .win(s1_win),
      .sum_n(t_sum),
      .min_pix(t_min),
      .max_pix(t_max)
   );
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v <= 1'b0;
         s1_win <= '0;
         s1_mode <= MODE_LAP;
`ifdef WINDOW_FILTER_THRESH_EN
         s1_thr <= '0;
         s1_thr_on <= 1'b0;
`else
`endif
      end else begin
         if (win_ready) s1_v <= win_valid;
         if (win_ready & win_valid) begin
            s1_win <= win_in;
            s1_mode <= mode_in;
`ifdef WINDOW_FILTER_THRESH_EN
            s1_thr <= thresh_in;
            s1_thr_on <= thresh_on;
`else
`endif
         end
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s2_v <= 1'b0;
         s2_sum <= '0;
         s2_min <= '0;
         s2_max <= '0;
         s2_cen <= '0;
         s2_mode <= MODE_LAP;
`ifdef WINDOW_FILTER_THRESH_EN
         s2_thr <= '0;
         s2_thr_on <= 1'b0;
`else
`endif
      end else begin
         if (s2_ld) s2_v <= s1_v;
         if (s1_adv) begin
            s2_sum <= t_sum;
            s2_min <= t_min;
            s2_max <= t_max;
            s2_cen <= s1_win[PIX_BIT*C +: PIX_BIT];
            s2_mode <= s1_mode;
`ifdef WINDOW_FILTER_THRESH_EN
            s2_thr <= s1_thr;
            s2_thr_on <= s1_thr_on;
`else
`endif
         end
      end
   end
   // SW is wide enough that (K-1)*cen and the full window sum never wrap
   always_comb begin
      cen_w = SW'(s2_cen);
      lap_prod = SW'(K - 1) * cen_w;
      lap_abs = (s2_sum >= lap_prod) ? s2_sum - lap_prod : lap_prod - s2_sum;
      box_val = (s2_sum + cen_w) >> BOX_SHIFT;
      raw = (s2_mode == MODE_MIN) ? s2_min :
            (s2_mode == MODE_MAX) ? s2_max :
            PIX_BIT'(saturate(32'((s2_mode == MODE_LAP) ? lap_abs : box_val), PIX_BIT));
`ifdef WINDOW_FILTER_THRESH_EN
      res = s2_thr_on ? ((raw >= s2_thr) ? '1 : '0) : raw;
`else
      res = raw;
`endif
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pix_valid <= 1'b0;
         pix_out <= '0;
      end else begin
         if (s3_ld) pix_valid <= s2_v;
         if (s2_adv) pix_out <= res;
      end
   end
endmodule

// File: tb/tb_window_filter_pipe.sv
// tb_window_filter_pipe: directed and randomized checks of window_filter_pipe against a behavioural model
module tb_window_filter_pipe;
   localparam int PB = 8;
   localparam int MW = 3;
   localparam int K = MW * MW;
   localparam int C = (K - 1) / 2;
   typedef struct {
      int px[K];
      int mode;
      int thr;
      int thr_on;
   } beat_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [PB*K-1:0] win_in = '0;
   logic win_valid = 1'b0;
   logic pix_ready = 1'b1;
   logic [1:0] mode_in = 2'd0;
   logic win_ready, pix_valid;
   logic [PB-1:0] pix_out;
`ifdef WINDOW_FILTER_THRESH_EN
   logic [PB-1:0] thresh_in = '0;
   logic thresh_on = 1'b0;
`endif
   int checks = 0;
   int failures = 0;
   beat_t in_q[$];
   int exp_q[$];
   window_filter_pipe #(.PIX_BIT(PB), .MASK_WIDTH(MW), .BOX_SHIFT(3)) dut (
      .clk(clk),
      .reset(rst_n),
      .win_in(win_in),
      .win_valid(win_valid),
      .win_ready(win_ready),
      .mode_in(mode_in),
`ifdef WINDOW_FILTER_THRESH_EN
      .thresh_in(thresh_in),
      .thresh_on(thresh_on),
`endif
      .pix_out(pix_out),
      .pix_valid(pix_valid),
      .pix_ready(pix_ready)
   );
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   function automatic int model(beat_t b);
      int sum, mn, mx, r;
      sum = 0;
      mn = 255;
      mx = 0;
      for (int i = 0; i < K; i++) begin
         sum += b.px[i];
         if (b.px[i] < mn) mn = b.px[i];
         if (b.px[i] > mx) mx = b.px[i];
      end
      if (b.mode == 0) begin
         r = (sum - b.px[C]) - (K - 1) * b.px[C];
         if (r < 0) r = -r;
      end else if (b.mode == 1) r = sum / 8;
      else if (b.mode == 2) r = mn;
      else r = mx;
      if (r > 255) r = 255;
      if (b.thr_on != 0) r = (r >= b.thr) ? 255 : 0;
      return r;
   endfunction
   function automatic beat_t fill(input int v, input int mode);
      beat_t b;
      for (int i = 0; i < K; i++) b.px[i] = v;
      b.mode = mode;
      b.thr = 0;
      b.thr_on = 0;
      return b;
   endfunction
   function automatic beat_t seq(input int mode);
      beat_t b;
      b = fill(0, mode);
      for (int i = 0; i < K; i++) b.px[i] = i + 1;
      return b;
   endfunction
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask
   task automatic drive(input beat_t b);
      for (int i = 0; i < K; i++) win_in[PB*i +: PB] = PB'(b.px[i]);
      mode_in = 2'(b.mode);
`ifdef WINDOW_FILTER_THRESH_EN
      thresh_in = PB'(b.thr);
      thresh_on = (b.thr_on != 0);
`endif
   endtask
   task automatic run_one(input string tag, input beat_t b, input int exp);
      @(negedge clk);
      drive(b);
      win_valid = 1'b1;
      pix_ready = 1'b1;
      #1 check({tag, "_win_ready"}, win_ready, 1);
      @(negedge clk);
      win_valid = 1'b0;
      check({tag, "_lat1"}, pix_valid, 0);
      @(negedge clk);
      check({tag, "_lat2"}, pix_valid, 0);
      @(negedge clk);
      check({tag, "_lat3_valid"}, pix_valid, 1);
      check(tag, pix_out, exp);
   endtask
   task automatic stream(input string tag, input int lo, input int hi, input bit rnd, output int held);
      int sent, recv, total, budget;
      bit pst;
      logic [PB-1:0] pout;
      sent = 0;
      recv = 0;
      total = in_q.size();
      budget = 20 * total + 50;
      pst = 1'b0;
      pout = '0;
      held = -1;
      exp_q.delete();
      for (int c = 0; c < budget && recv < total; c++) begin
         @(negedge clk);
         if (pst) begin
            check({tag, "_hold_valid"}, pix_valid, 1);
            check({tag, "_hold_data"}, pix_out, pout);
         end
         if (sent < total && (!rnd || $urandom_range(3) != 0)) begin
            drive(in_q[sent]);
            win_valid = 1'b1;
         end else win_valid = 1'b0;
         pix_ready = rnd ? ($urandom_range(2) != 0) : !(c >= lo && c <= hi);
         #1;
         if (win_valid && !win_ready && held < 0) held = sent - recv;
         if (win_valid && win_ready) begin
            exp_q.push_back(model(in_q[sent]));
            sent++;
         end
         if (pix_valid && pix_ready) begin
            if (exp_q.size() == 0) check({tag, "_extra"}, pix_valid, 0);
            else check(tag, pix_out, exp_q.pop_front());
            recv++;
         end
         pst = pix_valid && !pix_ready;
         pout = pix_out;
      end
      check({tag, "_count"}, recv, total);
      @(negedge clk);
      win_valid = 1'b0;
      pix_ready = 1'b1;
      check({tag, "_drained"}, pix_valid, 0);
   endtask
   initial begin
      beat_t b;
      int held;
      @(negedge clk);
      check("rst_pix_valid", pix_valid, 0);
      check("rst_pix_out", pix_out, 0);
      rst_n = 1'b1;
      #1 check("rst_win_ready", win_ready, 1);
      run_one("lap_flat", fill(10, 0), 0);
      b = fill(10, 0);
      b.px[C] = 50;
      run_one("lap_sat", b, 255);
      run_one("box_8", fill(8, 1), 9);
      run_one("box_sat", fill(255, 1), 255);
      run_one("min_seq", seq(2), 1);
      run_one("max_seq", seq(3), 9);
      in_q.delete();
      for (int i = 0; i < 4; i++) in_q.push_back(seq((i % 2 == 0) ? 2 : 3));
      stream("alt_minmax", 1, 0, 1'b0, held);
      in_q.delete();
      for (int v = 1; v <= 6; v++) in_q.push_back(fill(v, 1));
      stream("bp", 4, 9, 1'b0, held);
      check("bp_held_beats", held, 3);
      @(negedge clk);
      pix_ready = 1'b0;
      drive(fill(7, 1));
      win_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_valid", pix_valid, 1);
      win_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("rst_flush_valid", pix_valid, 0);
      check("rst_flush_out", pix_out, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      pix_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("rst_no_stale", pix_valid, 0);
      end
      run_one("rst_lat", fill(8, 1), 9);
      in_q.delete();
      for (int n = 0; n < 40; n++) begin
         int rng;
         rng = ($urandom_range(1) != 0) ? 255 : 15;
         b = fill(0, int'($urandom_range(3)));
         for (int i = 0; i < K; i++) b.px[i] = int'($urandom_range(rng));
`ifdef WINDOW_FILTER_THRESH_EN
         b.thr = int'($urandom_range(255));
         b.thr_on = int'($urandom_range(1));
`endif
         in_q.push_back(b);
      end
      stream("rand", 1, 0, 1'b1, held);
`ifdef WINDOW_FILTER_THRESH_EN
      b = fill(50, 3);
      b.px[2] = 120;
      b.thr = 100;
      b.thr_on = 1;
      run_one("thr_hi", b, 255);
      b.px[2] = 99;
      run_one("thr_lo", b, 0);
      b.thr_on = 0;
      run_one("thr_off", b, 99);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
